// File: rtl/sa_ctrl_pkg.sv
// Shared types and limits for the systolic-array load sequencer.
// The B address packs row and column into separate bit fields above B_BASE.
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        GAP    = 3'd2,
        LOAD_B = 3'd3,
        RUN    = 3'd4
    } state_t;

    localparam int unsigned A_MAX      = 25600;
    localparam int unsigned B_MAX_COLS = 50;
    localparam int unsigned B_MAX_ROWS = 16;
    localparam int unsigned COL_SHIFT  = 6;

    typedef struct packed {
        logic [1:0]  nth_conv;
        logic [14:0] a_len;
        logic [5:0]  b_cols;
        logic [4:0]  b_rows;
    } cfg_t;

    function automatic logic cfg_valid(input cfg_t c, input int unsigned a_max,
                                       input int unsigned cols_max, input int unsigned rows_max);
        return (32'(c.a_len) <= a_max) &&
               (c.b_cols != 6'd0) && (32'(c.b_cols) <= cols_max) &&
               (c.b_rows != 5'd0) && (32'(c.b_rows) <= rows_max);
    endfunction

endpackage

// File: rtl/sa_b_addr_gen.sv
// Row/column walker for the B region: one step per accepted beat,
// column wraps at i_cols-1, o_last marks the final element of the matrix.
module sa_b_addr_gen #(
    parameter int unsigned           ADDR_WIDTH = 17,
    parameter logic [ADDR_WIDTH-1:0] B_BASE     = 17'h08000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_adv,
    input  logic [5:0]            i_cols,
    input  logic [4:0]            i_rows,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);
    import sa_ctrl_pkg::*;

    logic [3:0] r_row;
    logic [5:0] r_col;
    logic       w_col_wrap;

    assign w_col_wrap = (r_col == (i_cols - 6'd1));
    assign o_last     = w_col_wrap && ({1'b0, r_row} == (i_rows - 5'd1));

    // Fields are OR'd into the base so a row never carries into B_BASE bits.
    assign o_addr = B_BASE | (ADDR_WIDTH'(r_row) << COL_SHIFT) | ADDR_WIDTH'(r_col);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_adv) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= r_row + 4'd1;
            end else begin
                r_col <= r_col + 6'd1;
            end
        end
    end

endmodule

// File: rtl/sa_load_ctrl.sv
// Loads a byte stream into the SA buffer (linear A, then packed B), then
// holds start with the conv index until the array reports completion.
module sa_load_ctrl #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ADDR_WIDTH = 17,
    parameter logic [ADDR_WIDTH-1:0] A_BASE     = 17'h00000,
    parameter int unsigned           A_MAX      = sa_ctrl_pkg::A_MAX,
    parameter logic [ADDR_WIDTH-1:0] B_BASE     = 17'h08000,
    parameter int unsigned           B_MAX_COLS = sa_ctrl_pkg::B_MAX_COLS,
    parameter int unsigned           B_MAX_ROWS = sa_ctrl_pkg::B_MAX_ROWS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_nth_conv,
    input  logic [14:0]           cmd_a_len,
    input  logic [5:0]            cmd_b_cols,
    input  logic [4:0]            cmd_b_rows,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] dia,
    output logic                  start,
    output logic [1:0]            nth_conv_o,
    input  logic                  sa_done,
    output logic                  done_o,
    output logic                  err_o,
    output logic [2:0]            dbg_state
);
    import sa_ctrl_pkg::*;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // ready never depends on valid, and both ready outputs drop while rst is high.

    state_t                r_state;
    cfg_t                  r_cfg;
    logic [14:0]           r_a_idx;
    logic                  r_cmd_ready;
    logic                  r_wea;
    logic [ADDR_WIDTH-1:0] r_addra;
    logic [DATA_WIDTH-1:0] r_dia;
    logic                  r_start;
    logic [1:0]            r_nth;
    logic                  r_done;
    logic                  r_err;

    cfg_t                  w_cmd_cfg;
    logic                  w_cmd_ok;
    logic                  w_cmd_fire;
    logic                  w_beat;
    logic                  w_b_clr;
    logic                  w_b_adv;
    logic                  w_b_last;
    logic [ADDR_WIDTH-1:0] w_b_addr;

    assign w_cmd_cfg  = '{nth_conv: cmd_nth_conv, a_len: cmd_a_len,
                          b_cols: cmd_b_cols, b_rows: cmd_b_rows};
    assign w_cmd_ok   = cfg_valid(w_cmd_cfg, A_MAX, B_MAX_COLS, B_MAX_ROWS);
    assign cmd_ready  = r_cmd_ready & ~rst;
    assign s_ready    = ((r_state == LOAD_A) || (r_state == LOAD_B)) & ~rst;
    assign w_cmd_fire = cmd_valid & cmd_ready;
    assign w_beat     = s_valid & s_ready;
    assign w_b_clr    = (r_state == GAP);
    assign w_b_adv    = w_beat && (r_state == LOAD_B);

    sa_b_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .B_BASE     (B_BASE)
    ) u_b_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_b_clr),
        .i_adv  (w_b_adv),
        .i_cols (r_cfg.b_cols),
        .i_rows (r_cfg.b_rows),
        .o_addr (w_b_addr),
        .o_last (w_b_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cfg       <= '0;
            r_a_idx     <= '0;
            r_cmd_ready <= 1'b0;
            r_wea       <= 1'b0;
            r_addra     <= '0;
            r_dia       <= '0;
            r_start     <= 1'b0;
            r_nth       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wea  <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_fire && w_cmd_ok) begin
                        r_cfg       <= w_cmd_cfg;
                        r_a_idx     <= '0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= (cmd_a_len == 15'd0) ? GAP : LOAD_A;
                    end else if (w_cmd_fire) begin
                        r_err <= 1'b1;
                    end
                end
                LOAD_A: begin
                    if (w_beat) begin
                        r_wea   <= 1'b1;
                        r_addra <= A_BASE + ADDR_WIDTH'(r_a_idx);
                        r_dia   <= s_data;
                        r_a_idx <= r_a_idx + 15'd1;
                        if (r_a_idx == (r_cfg.a_len - 15'd1)) begin
                            r_state <= GAP;
                        end
                    end
                end
                GAP: begin
                    r_state <= LOAD_B;
                end
                LOAD_B: begin
                    if (w_beat) begin
                        r_wea   <= 1'b1;
                        r_addra <= w_b_addr;
                        r_dia   <= s_data;
                        if (w_b_last) begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // start rises one cycle after entry; sa_done only counts once it is up.
                    if (!r_start) begin
                        r_start <= 1'b1;
                        r_nth   <= r_cfg.nth_conv;
                    end else if (sa_done) begin
                        r_start     <= 1'b0;
                        r_done      <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wea        = r_wea;
    assign addra      = r_addra;
    assign dia        = r_dia;
    assign start      = r_start;
    assign nth_conv_o = r_nth;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_sa_load_ctrl.sv
// Scoreboarded bench for sa_load_ctrl: each accepted stream beat queues the
// address/data it must appear as on the buffer write port one cycle later.
module tb_sa_load_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_nth_conv;
    logic [14:0] cmd_a_len;
    logic [5:0]  cmd_b_cols;
    logic [4:0]  cmd_b_rows;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        wea;
    logic [16:0] addra;
    logic [7:0]  dia;
    logic        start;
    logic [1:0]  nth_conv_o;
    logic        sa_done;
    logic        done_o;
    logic        err_o;
    logic [2:0]  dbg_state;

    sa_load_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_nth_conv (cmd_nth_conv),
        .cmd_a_len    (cmd_a_len),
        .cmd_b_cols   (cmd_b_cols),
        .cmd_b_rows   (cmd_b_rows),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .wea          (wea),
        .addra        (addra),
        .dia          (dia),
        .start        (start),
        .nth_conv_o   (nth_conv_o),
        .sa_done      (sa_done),
        .done_o       (done_o),
        .err_o        (err_o),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    localparam int W = 25;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    int           n_checks = 0;
    int           n_errors = 0;
    int           wr_cnt   = 0;
    int           done_cnt = 0;
    int           err_cnt  = 0;
    bit           hold_en  = 1'b0;
    logic [16:0]  prev_addra = '0;
    logic [7:0]   prev_dia   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (wea === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("wea_unexpected", 32'(wea), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(addra), 32'(e[24:8]));
                check("wr_data", 32'(dia), 32'(e[7:0]));
            end
        end else if (hold_en) begin
            check("addra_hold", 32'(addra), 32'(prev_addra));
            check("dia_hold", 32'(dia), 32'(prev_dia));
        end
        if (done_o === 1'b1) done_cnt++;
        if (err_o === 1'b1) err_cnt++;
        prev_addra = addra;
        prev_dia   = dia;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cmd_ready();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    task automatic drive_cmd(input int a_len, input int cols, input int rows, input int nth);
        cmd_valid    = 1'b1;
        cmd_a_len    = 15'(a_len);
        cmd_b_cols   = 6'(cols);
        cmd_b_rows   = 5'(rows);
        cmd_nth_conv = 2'(nth);
    endtask

    task automatic run_job(input int a_len, input int cols, input int rows, input int nth,
                           input bit toggle, input bit spur, input bit busy);
        logic [16:0] addrs[$];
        logic [7:0]  d;
        logic        v;
        int          n, cyc, budget, done0, wr0, err0;
        for (int i = 0; i < a_len; i++) addrs.push_back(17'(i));
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                addrs.push_back(17'h08000 | 17'(r << 6) | 17'(c));
        n      = addrs.size();
        budget = 2 * n + 20;
        done0  = done_cnt;
        wr0    = wr_cnt;
        err0   = err_cnt;

        wait_cmd_ready();
        drive_cmd(a_len, cols, rows, nth);
        @(negedge clk);
        cmd_valid = 1'b0;

        cyc = 0;
        while (addrs.size() > 0 && cyc < budget) begin
            d       = 8'($urandom_range(0, 255));
            v       = toggle ? ((cyc % 2) == 1) : 1'b1;
            s_valid = v;
            s_data  = d;
            if (spur) sa_done = (cyc == 2);
            if (v && s_ready) exp_q.push_back({addrs.pop_front(), d});
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        sa_done = 1'b0;
        check("load_timeout", 32'(addrs.size()), 32'd0);
        if (!toggle) check("load_cycles", 32'(cyc), 32'(n + 1));

        for (int i = 0; i < 10; i++) begin
            if (start) break;
            @(negedge clk);
        end
        check("start", 32'(start), 32'd1);
        check("nth_conv", 32'(nth_conv_o), 32'(nth));
        check("q_drained", 32'(exp_q.size()), 32'd0);
        check("wr_count", 32'(wr_cnt - wr0), 32'(n));
        check("s_ready_run", 32'(s_ready), 32'd0);

        if (busy) begin
            drive_cmd(5, 2, 2, 3);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
                check("busy_start", 32'(start), 32'd1);
            end
            cmd_valid = 1'b0;
        end
        repeat ($urandom_range(1, 4)) @(negedge clk);
        check("start_hold", 32'(start), 32'd1);
        check("done_early", 32'(done_cnt - done0), 32'd0);

        sa_done = 1'b1;
        @(negedge clk);
        sa_done = 1'b0;
        check("start_drop", 32'(start), 32'd0);
        check("done_pulse", 32'(done_o), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(done_o), 32'd0);
        check("cmd_ready_after", 32'(cmd_ready), 32'd1);
        check("done_count", 32'(done_cnt - done0), 32'd1);
        check("no_err", 32'(err_cnt - err0), 32'd0);
    endtask

    task automatic bad_cmd(input int a_len, input int cols, input int rows);
        wait_cmd_ready();
        drive_cmd(a_len, cols, rows, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("err_pulse", 32'(err_o), 32'd1);
        check("err_cmd_ready", 32'(cmd_ready), 32'd1);
        check("err_no_wea", 32'(wea), 32'd0);
        @(negedge clk);
        check("err_one_cycle", 32'(err_o), 32'd0);
        check("err_state_idle", 32'(dbg_state), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_nth_conv = '0;
        cmd_a_len    = '0;
        cmd_b_cols   = '0;
        cmd_b_rows   = '0;
        s_valid      = 1'b0;
        s_data       = '0;
        sa_done      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wea", 32'(wea), 32'd0);
        check("rst_addra", 32'(addra), 32'd0);
        check("rst_dia", 32'(dia), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_nth", 32'(nth_conv_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_post_rst", 32'(cmd_ready), 32'd1);
        hold_en = 1'b1;

        run_job(1024, 50, 16, 1, 1'b0, 1'b0, 1'b0);
        run_job(1024, 50, 16, 1, 1'b1, 1'b0, 1'b0);
        run_job(0, 1, 1, 2, 1'b0, 1'b0, 1'b0);

        bad_cmd(100, 51, 4);
        bad_cmd(100, 50, 0);
        bad_cmd(25601, 50, 16);
        bad_cmd(100, 0, 4);
        bad_cmd(100, 50, 17);

        // Reset in the middle of LOAD_B, at row 5.
        wait_cmd_ready();
        drive_cmd(4, 10, 8, 2);
        @(negedge clk);
        cmd_valid = 1'b0;
        acc = 0;
        for (int i = 0; i < 200 && acc < 4 + 5 * 10 + 3; i++) begin
            s_data  = 8'($urandom_range(0, 255));
            s_valid = 1'b1;
            if (s_ready) begin
                if (acc < 4) exp_q.push_back({17'(acc), s_data});
                else exp_q.push_back({17'h08000 | 17'(((acc - 4) / 10) << 6) | 17'((acc - 4) % 10), s_data});
                acc++;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        hold_en = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check("midrst_wea", 32'(wea), 32'd0);
        check("midrst_start", 32'(start), 32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        check("midrst_q", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_release", 32'(cmd_ready), 32'd1);
        check("midrst_addra", 32'(addra), 32'd0);
        hold_en = 1'b1;
        run_job(3, 2, 2, 3, 1'b0, 1'b0, 1'b0);

        run_job(20, 3, 2, 1, 1'b0, 1'b1, 1'b1);
        run_job(25600, 1, 1, 0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
